// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the MEM stage:
// access-size encodings and the responder FSM state encoding.
package dmem_pkg;

    typedef enum logic [1:0] {
        SIZE_WORD  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_BYTE  = 2'd2,
        SIZE_WORD3 = 2'd3
    } dmem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Width of the wait-state counter (latency 0..15).
    localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_lane_merge.sv
// Write-lane merge: replaces the low byte, low halfword or whole word of
// the old slot value with the low-aligned new data. Size 3 acts as word.
module dmem_lane_merge
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_old,
    input  logic [WIDTH-1:0] i_new,
    input  logic [1:0]       i_size,
    output logic [WIDTH-1:0] o_merged
);

    logic [WIDTH-1:0] lane_mask;

    // Select the lanes that take new data, then blend with the old word.
    always_comb begin
        lane_mask = '1;
        case (dmem_size_e'(i_size))
            SIZE_BYTE: begin
                lane_mask       = '0;
                lane_mask[7:0]  = '1;
            end
            SIZE_HALF: begin
                lane_mask       = '0;
                lane_mask[15:0] = '1;
            end
            default: lane_mask = '1;
        endcase
        o_merged = (i_old & ~lane_mask) | (i_new & lane_mask);
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: valid/ready request and response handshakes in
// front of a small word-addressed memory with configurable wait states.
// Define DMEM_DEBUG_BUS_EN to expose all slots on o_bus_debug.
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int unsigned IO_BUS_SIZE   = 32,
    parameter int unsigned MEM_ADDR_SIZE = 5,
    parameter int unsigned WAIT_STATES   = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_wr_rd,
    input  logic [1:0]               i_size,
    input  logic [MEM_ADDR_SIZE-1:0] i_addr,
    input  logic [IO_BUS_SIZE-1:0]   i_data,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [IO_BUS_SIZE-1:0]   o_rdata
`ifdef DMEM_DEBUG_BUS_EN
    ,
    output logic [(2**MEM_ADDR_SIZE)*IO_BUS_SIZE-1:0] o_bus_debug
`endif
);

    localparam int unsigned DEPTH = 2**MEM_ADDR_SIZE;

    dmem_state_e               state_q, state_d;
    logic [WAIT_CNT_W-1:0]     cnt_q, cnt_d;
    logic                      wr_q, wr_d;
    logic [1:0]                size_q, size_d;
    logic [MEM_ADDR_SIZE-1:0]  addr_q, addr_d;
    logic [IO_BUS_SIZE-1:0]    data_q, data_d;
    logic [IO_BUS_SIZE-1:0]    rdata_q, rdata_d;
    logic [IO_BUS_SIZE-1:0]    mem_q [DEPTH];
    logic [IO_BUS_SIZE-1:0]    mem_d [DEPTH];

    logic                      accept;
    logic                      commit;
    logic                      op_wr;
    logic [1:0]                op_size;
    logic [MEM_ADDR_SIZE-1:0]  op_addr;
    logic [IO_BUS_SIZE-1:0]    op_data;
    logic [IO_BUS_SIZE-1:0]    old_word;
    logic [IO_BUS_SIZE-1:0]    merged_word;

    assign o_req_ready = (state_q == ST_IDLE) && !i_flush && !i_reset;
    assign accept      = o_req_ready && i_req_valid;
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rdata     = rdata_q;

    // With zero wait states the commit happens in the acceptance cycle, so
    // the access operands come straight from the request inputs in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_wr   = i_wr_rd;
            op_size = i_size;
            op_addr = i_addr;
            op_data = i_data;
        end else begin
            op_wr   = wr_q;
            op_size = size_q;
            op_addr = addr_q;
            op_data = data_q;
        end
    end

    assign old_word = mem_q[op_addr];

    dmem_lane_merge #(
        .WIDTH (IO_BUS_SIZE)
    ) u_lane_merge (
        .i_old    (old_word),
        .i_new    (op_data),
        .i_size   (op_size),
        .o_merged (merged_word)
    );

    // Next-state, capture, commit and flush logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        mem_d   = mem_q;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_d   = i_wr_rd;
                    size_d = i_size;
                    addr_d = i_addr;
                    data_d = i_data;
                    cnt_d  = WAIT_CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        commit = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Commit in the cycle the decremented count reaches zero,
                // giving exactly WAIT_STATES cycles in WAIT.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    commit = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit) begin
            if (op_wr) begin
                mem_d[op_addr] = merged_word;
                rdata_d        = merged_word;
            end else begin
                rdata_d = old_word;
            end
            state_d = ST_RESP;
        end

        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rdata_d = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end
    end

    // State, capture and memory registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            mem_q   <= mem_d;
        end
    end

`ifdef DMEM_DEBUG_BUS_EN
    // Flatten all slots, slot 0 in the LSBs.
    always_comb begin
        o_bus_debug = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            o_bus_debug[i*IO_BUS_SIZE +: IO_BUS_SIZE] = mem_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with one wait
// state, one with zero wait states. Debug-bus checks need DMEM_DEBUG_BUS_EN.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    int          vectors = 0;
    int          miscompares = 0;

    // One-wait-state instance
    logic        flush1, valid1, ready1, wr1, rsp_valid1, rsp_ready1;
    logic [1:0]  size1;
    logic [4:0]  addr1;
    logic [31:0] data1, rdata1;
    // Zero-wait-state instance
    logic        flush0, valid0, ready0, wr0, rsp_valid0, rsp_ready0;
    logic [1:0]  size0;
    logic [4:0]  addr0;
    logic [31:0] data0, rdata0;
`ifdef DMEM_DEBUG_BUS_EN
    logic [1023:0] dbg1, dbg0;
`endif

    always #5 clk = ~clk;

    data_memory_responder #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5), .WAIT_STATES(1)) dut1 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush1), .i_req_valid(valid1),
        .o_req_ready(ready1), .i_wr_rd(wr1), .i_size(size1), .i_addr(addr1),
        .i_data(data1), .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1),
        .o_rdata(rdata1)
`ifdef DMEM_DEBUG_BUS_EN
        , .o_bus_debug(dbg1)
`endif
    );

    data_memory_responder #(.IO_BUS_SIZE(32), .MEM_ADDR_SIZE(5), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_flush(flush0), .i_req_valid(valid0),
        .o_req_ready(ready0), .i_wr_rd(wr0), .i_size(size0), .i_addr(addr0),
        .i_data(data0), .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready0),
        .o_rdata(rdata0)
`ifdef DMEM_DEBUG_BUS_EN
        , .o_bus_debug(dbg0)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the one-wait instance and collect its response;
    // lat counts cycles from acceptance until o_rsp_valid is seen.
    task automatic txn1(input logic wr, input logic [1:0] sz, input logic [4:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        int guard;
        wr1 = wr; size1 = sz; addr1 = a; data1 = d; valid1 = 1'b1;
        guard = 0;
        while (ready1 !== 1'b1 && guard < 20) begin step(); guard++; end
        step();
        valid1 = 1'b0;
        lat = 1;
        while (rsp_valid1 !== 1'b1 && lat < 20) begin step(); lat++; end
        rd = rdata1;
        rsp_ready1 = 1'b1;
        if (rsp_valid1 === 1'b1) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        vectors++; if (rsp_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid1); end
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h exp 00000000", rdata1); end
        vectors++; if (ready1 !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got %b exp 0", ready1); end
        vectors++; if (ready0 !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready_ws0 got %b exp 0", ready0); end
        rst = 1'b0;
        #1;
        vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL post_reset_req_ready got %b exp 1", ready1); end
    endtask

    task automatic test_read_after_reset();
        logic [31:0] rd; int lat;
        txn1(1'b0, 2'd0, 5'd3, 32'hFFFF_FFFF, rd, lat);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL read3_data got %h exp 00000000", rd); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL read3_latency got %0d exp 2", lat); end
    endtask

    task automatic test_lane_merge();
        logic [31:0] rd; int lat;
        txn1(1'b1, 2'd0, 5'd5, 32'hDEAD_BEEF, rd, lat);
        vectors++; if (rd !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL word_write got %h exp deadbeef", rd); end
        txn1(1'b1, 2'd2, 5'd5, 32'h0000_0011, rd, lat);
        vectors++; if (rd !== 32'hDEAD_BE11) begin miscompares++; $display("FAIL byte_write got %h exp deadbe11", rd); end
        txn1(1'b0, 2'd0, 5'd5, 32'h0, rd, lat);
        vectors++; if (rd !== 32'hDEAD_BE11) begin miscompares++; $display("FAIL byte_readback got %h exp deadbe11", rd); end
        txn1(1'b1, 2'd1, 5'd5, 32'hFFFF_2222, rd, lat);
        vectors++; if (rd !== 32'hDEAD_2222) begin miscompares++; $display("FAIL half_write got %h exp dead2222", rd); end
        txn1(1'b0, 2'd2, 5'd5, 32'h0, rd, lat);
        vectors++; if (rd !== 32'hDEAD_2222) begin miscompares++; $display("FAIL read_ignores_size got %h exp dead2222", rd); end
        txn1(1'b1, 2'd3, 5'd9, 32'hA5A5_5A5A, rd, lat);
        vectors++; if (rd !== 32'hA5A5_5A5A) begin miscompares++; $display("FAIL size3_word_write got %h exp a5a55a5a", rd); end
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL write_latency got %0d exp 2", lat); end
    endtask

    task automatic test_backpressure();
        rsp_ready1 = 1'b0;
        wr1 = 1'b0; size1 = 2'd0; addr1 = 5'd5; data1 = 32'h0; valid1 = 1'b1;
        step();                        // accepted
        wr1 = 1'b1; addr1 = 5'd6; data1 = 32'h0000_00AA;
        vectors++; if (ready1 !== 1'b0) begin miscompares++; $display("FAIL bp_ready_in_wait got %b exp 0", ready1); end
        step();                        // commit -> RESP
        for (int i = 0; i < 4; i++) begin
            vectors++; if (rsp_valid1 !== 1'b1) begin miscompares++; $display("FAIL bp_valid_held[%0d] got %b exp 1", i, rsp_valid1); end
            vectors++; if (rdata1 !== 32'hDEAD_2222) begin miscompares++; $display("FAIL bp_rdata_stable[%0d] got %h exp dead2222", i, rdata1); end
            vectors++; if (ready1 !== 1'b0) begin miscompares++; $display("FAIL bp_req_ready[%0d] got %b exp 0", i, ready1); end
            step();
        end
        rsp_ready1 = 1'b1;
        step();                        // handshake -> IDLE
        vectors++; if (rsp_valid1 !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop got %b exp 0", rsp_valid1); end
        vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL bp_ready_after_hs got %b exp 1", ready1); end
        step();                        // pending write accepted
        valid1 = 1'b0;
        vectors++; if (rsp_valid1 !== 1'b0) begin miscompares++; $display("FAIL bp_second_early got %b exp 0", rsp_valid1); end
        step();
        vectors++; if (rsp_valid1 !== 1'b1) begin miscompares++; $display("FAIL bp_second_valid got %b exp 1", rsp_valid1); end
        vectors++; if (rdata1 !== 32'h0000_00AA) begin miscompares++; $display("FAIL bp_second_rdata got %h exp 000000aa", rdata1); end
        step();                        // handshake
    endtask

    task automatic test_flush();
        logic [31:0] rd; int lat;
        wr1 = 1'b1; size1 = 2'd0; addr1 = 5'd2; data1 = 32'h1234_5678; valid1 = 1'b1;
        step();                        // accepted -> WAIT
        valid1 = 1'b0;
        flush1 = 1'b1;
        step();
        flush1 = 1'b0;
        #1;
        vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL flush_ready_after got %b exp 1", ready1); end
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL flush_rdata got %h exp 00000000", rdata1); end
        for (int i = 0; i < 3; i++) begin
            vectors++; if (rsp_valid1 !== 1'b0) begin miscompares++; $display("FAIL flush_no_rsp[%0d] got %b exp 0", i, rsp_valid1); end
            step();
        end
        txn1(1'b0, 2'd0, 5'd2, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL flush_addr2 got %h exp 00000000", rd); end
        txn1(1'b0, 2'd0, 5'd5, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL flush_addr5 got %h exp 00000000", rd); end
    endtask

    task automatic test_reset_flush_in_resp();
        logic [31:0] rd; int lat;
        rsp_ready1 = 1'b0;
        wr1 = 1'b1; size1 = 2'd0; addr1 = 5'd7; data1 = 32'h0000_0055; valid1 = 1'b1;
        step();
        valid1 = 1'b0;
        step();
        vectors++; if (rsp_valid1 !== 1'b1 || rdata1 !== 32'h55) begin miscompares++; $display("FAIL rf_resp got valid %b data %h exp 1 00000055", rsp_valid1, rdata1); end
        rst = 1'b1; flush1 = 1'b1;
        #1;
        vectors++; if (ready1 !== 1'b0) begin miscompares++; $display("FAIL rf_ready_during got %b exp 0", ready1); end
        step();
        vectors++; if (rsp_valid1 !== 1'b0) begin miscompares++; $display("FAIL rf_valid got %b exp 0", rsp_valid1); end
        vectors++; if (rdata1 !== 32'h0) begin miscompares++; $display("FAIL rf_rdata got %h exp 00000000", rdata1); end
        rst = 1'b0; flush1 = 1'b0;
        #1;
        vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL rf_idle got %b exp 1", ready1); end
        txn1(1'b0, 2'd0, 5'd7, 32'h0, rd, lat);
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rf_addr7 got %h exp 00000000", rd); end
    endtask

    task automatic test_back_to_back();
        wr0 = 1'b1; size0 = 2'd0; addr0 = 5'd0; data0 = 32'hCAFE_F00D; valid0 = 1'b1;
        step();                        // accept + commit
        vectors++; if (rsp_valid0 !== 1'b1 || rdata0 !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL b2b_first got valid %b data %h exp 1 cafef00d", rsp_valid0, rdata0); end
        addr0 = 5'd1; data0 = 32'h0BAD_BEEF;
        step();                        // handshake
        vectors++; if (rsp_valid0 !== 1'b0 || ready0 !== 1'b1) begin miscompares++; $display("FAIL b2b_gap got valid %b ready %b exp 0 1", rsp_valid0, ready0); end
        step();
        vectors++; if (rsp_valid0 !== 1'b1 || rdata0 !== 32'h0BAD_BEEF) begin miscompares++; $display("FAIL b2b_second got valid %b data %h exp 1 0badbeef", rsp_valid0, rdata0); end
        addr0 = 5'd0; size0 = 2'd2; data0 = 32'h0000_0077;
        step();
        step();
        valid0 = 1'b0;
        vectors++; if (rsp_valid0 !== 1'b1 || rdata0 !== 32'hCAFE_F077) begin miscompares++; $display("FAIL b2b_byte got valid %b data %h exp 1 cafef077", rsp_valid0, rdata0); end
        step();
        vectors++; if (rsp_valid0 !== 1'b0) begin miscompares++; $display("FAIL b2b_done got %b exp 0", rsp_valid0); end
`ifdef DMEM_DEBUG_BUS_EN
        begin
            logic [63:0] lo;
            lo = dbg0[63:0];
            vectors++; if (lo !== 64'h0BAD_BEEF_CAFE_F077) begin miscompares++; $display("FAIL b2b_debug_bus got %h exp 0badbeefcafef077", lo); end
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        flush1 = 1'b0; valid1 = 1'b0; wr1 = 1'b0; size1 = '0; addr1 = '0; data1 = '0; rsp_ready1 = 1'b1;
        flush0 = 1'b0; valid0 = 1'b0; wr0 = 1'b0; size0 = '0; addr0 = '0; data0 = '0; rsp_ready0 = 1'b1;
        test_reset();
        test_read_after_reset();
        test_lane_merge();
        test_backpressure();
        test_flush();
        test_reset_flush_in_resp();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter IO_BUS_SIZE, default 32: data word width.
REQ-002 SHALL have parameter MEM_ADDR_SIZE, default 5: word address width; depth is 2**MEM_ADDR_SIZE slots.
REQ-003 SHALL have parameter WAIT_STATES, default 1: access latency in cycles, legal range 0..15.
REQ-004 SHALL have i_clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have i_reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have i_flush, input, 1: clear memory and abort any transaction in flight.
REQ-007 SHALL have i_req_valid, input, 1: request present.
REQ-008 SHALL have o_req_ready, output, 1: request accepted when high together with i_req_valid.
REQ-009 SHALL have i_wr_rd, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have i_size, input, 2: 0 = word, 1 = halfword, 2 = byte, 3 = word.
REQ-011 SHALL have i_addr, input, MEM_ADDR_SIZE: word address.
REQ-012 SHALL have i_data, input, IO_BUS_SIZE: write data, low-aligned.
REQ-013 SHALL have o_rsp_valid, output, 1: response present.
REQ-014 SHALL have i_rsp_ready, input, 1: response consumed when high together with o_rsp_valid.
REQ-015 SHALL have o_rdata, output, IO_BUS_SIZE: slot contents after the access.
REQ-016 SHALL have o_bus_debug, output, 2**MEM_ADDR_SIZE*IO_BUS_SIZE: all slots concatenated, slot 0 in the LSBs (present only per REQ-030).

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-018 SHALL drive o_req_ready = (state == IDLE) and not i_flush.
REQ-019 SHALL, on acceptance, register i_wr_rd, i_size, i_addr and i_data, and load the wait counter with WAIT_STATES.
REQ-020 SHALL decrement the counter once per cycle in WAIT and commit the access in the cycle it equals 0; with WAIT_STATES = 0, IDLE goes directly to the commit cycle.
REQ-021 SHALL, at commit: a write merges the low 8, 16 or 32 bits of the captured data into the slot by i_size and preserves the upper bits; a read leaves the slot unchanged; o_rdata registers the resulting slot value; state goes to RESP.
REQ-022 SHALL hold o_rsp_valid high in RESP, with o_rdata stable, until i_rsp_ready is high; it then returns to IDLE in the next cycle.
REQ-023 SHALL give acceptance-to-o_rsp_valid latency of exactly WAIT_STATES + 1 cycles.
REQ-024 SHALL allow back-to-back requests: the next request is accepted in the first IDLE cycle after the response handshake.
REQ-025 SHALL, when i_flush is high, zero all slots, go to IDLE, drop o_rsp_valid and o_rdata to 0, and emit no response for an aborted transaction.
REQ-026 SHALL give i_flush priority over a simultaneous request, commit or response handshake.
REQ-027 SHALL ignore i_size for reads and treat i_size = 3 as word for writes.

Reset
REQ-028 SHALL, while i_reset is high: state = IDLE, counter = 0, all slots = 0, o_rsp_valid = 0, o_rdata = 0, o_req_ready = 0.
REQ-029 SHALL give i_reset priority over i_flush; reset mid-transaction discards the transaction.

Configuration
REQ-030 SHALL, with macro DMEM_DEBUG_BUS_EN defined, include o_bus_debug driven combinationally from the slots.
REQ-031 SHALL, without DMEM_DEBUG_BUS_EN, omit the o_bus_debug port; all other behaviour is identical.

Structure
REQ-032 SHALL take the size encodings (SIZE_WORD, SIZE_HALF, SIZE_BYTE) and the FSM state encoding from shared package dmem_pkg; the MEM stage uses the same package.
REQ-033 SHALL implement the write merge in one combinational sub-module, dmem_lane_merge (old word, new data, size -> merged word).

Verification
REQ-034 SHALL cover: reset, then read addr 3 -> o_rdata = 0x00000000, valid 2 cycles after acceptance (WAIT_STATES = 1).
REQ-035 SHALL cover: word write 0xDEADBEEF to addr 5, then byte write 0x00000011 to addr 5, then read -> 0xDEADBE11; halfword write 0x2222 -> 0xDEAD2222.
REQ-036 SHALL cover: i_rsp_ready held low 4 cycles -> o_rsp_valid and o_rdata stable, o_req_ready low throughout, a pending request accepted only after the handshake.
REQ-037 SHALL cover: i_flush asserted in WAIT of a write 0x12345678 to addr 2 -> no response, addr 2 reads 0, o_req_ready high the cycle after flush deasserts.
REQ-038 SHALL cover: WAIT_STATES = 0, back-to-back writes to addr 0/1 with i_rsp_ready tied high -> one response per 2 cycles, o_bus_debug[63:0] matches the written data.
REQ-039 SHALL cover: i_reset and i_flush high together during RESP -> all outputs 0, state IDLE.
